alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the MIPS core datapath, the next-generation integer execution unit. It performs registered single-cycle logic/arithmetic/compare operations and adds iterative unsigned multiply and divide with HI/LO-style outputs. It sits between the operand/decode stage and writeback. Handshake sideband signals let the control unit stall while a multi-cycle operation is in progress.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  reset, asynchronous and active-low
- i_valid  in  1  operation request; accepted when i_valid && o_ready at a rising edge
- i_control  in  4  operation code (see Operation)
- i_op1  in  WIDTH  operand A / dividend / multiplicand
- i_op2  in  WIDTH  operand B / divisor / multiplier
- o_ready  out  1  unit can accept a request this cycle
- o_valid  out  1  one-cycle pulse; o_result/o_hi/o_zf/o_dz are new this cycle
- o_result  out  WIDTH  result, product low half, or quotient
- o_hi  out  WIDTH  product high half or remainder; 0 for single-cycle ops
- o_zf  out  1  o_result == 0, registered with o_result
- o_dz  out  1  divide-by-zero flag for the current result

## Operation
- Single-cycle ops:
  - AND 0000: op1&op2
  - OR 0001: op1|op2
  - ADD 0010: op1+op2, modulo 2^WIDTH, no overflow trap
  - SUB 0110: op1-op2, modulo 2^WIDTH
  - SLT 0111: signed less-than, result 1 or 0
  - SLTU 1000: unsigned less-than
  - NOR 1100: ~(op1|op2)
  - Any unlisted code: result 0, o_hi 0, o_valid still pulses
- Multi-cycle ops:
  - MULTU 1010: {o_hi,o_result} = op1*op2, full 2*WIDTH-bit unsigned product; shift-add, one multiplier bit per cycle
  - DIVU 1011: o_result = op1/op2, o_hi = op1%op2, unsigned; restoring division, one quotient bit per cycle
- Divide by zero (DIVU with op2==0): o_result all ones, o_hi = op1, o_dz=1. Full WIDTH-cycle latency still applies; no early exit. o_dz=0 for every other result.
- Operands and opcode are captured at acceptance. Input changes during BUSY have no effect.
- State machine:
  - IDLE (o_ready=1)
    - Accept single-cycle op: result registered on the accepting edge, o_valid=1 next cycle, stay IDLE.
    - Accept MULTU/DIVU: load working registers, iteration counter = WIDTH, go to BUSY.
  - BUSY (o_ready=0)
    - Each edge performs one iteration and decrements the counter.
    - On the edge where the counter reaches 0: register the final result, assert o_valid, go to IDLE.
- Outputs hold their last value until the next o_valid. o_valid never asserts without a prior accept.
- No output backpressure: the consumer must take the result in the o_valid cycle.

## Timing
- Reset (i_rst_n=0, immediate and asynchronous): state IDLE, counter 0, o_ready=1, o_valid=0, o_result=0, o_hi=0, o_zf=0, o_dz=0.
- Reset asserted mid-BUSY aborts the operation. No o_valid is produced for it.
- Single-cycle latency: accept at edge N -> o_valid high in the cycle after edge N. Throughput is 1 op/cycle; back-to-back accepts produce back-to-back o_valid.
- Multi-cycle latency: accept at edge N -> o_ready low from edge N -> o_valid high and o_ready high after edge N+WIDTH.
- Accept in the o_valid cycle is legal:
  - The new op starts.
  - The previous result stays visible only during that o_valid cycle.
- i_valid while o_ready=0 is ignored and not queued. The requester holds i_valid until accepted.
- WIDTH=32: MULTU/DIVU take 32 busy cycles; o_valid arrives on the 32nd edge after acceptance.

## Test plan
- Reset then ADD 0x7FFFFFFF+1 -> next cycle o_valid=1, o_result=0x80000000, o_zf=0. Then SUB 5-5 -> o_result=0, o_zf=1.
- SLT 0xFFFFFFFF vs 1 -> o_result=1. SLTU with same operands -> o_result=0. NOR 0,0 -> 0xFFFFFFFF. Opcode 1111 -> o_result=0, o_valid=1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF:
  - o_ready=0 for 32 cycles.
  - o_valid on edge 32 after accept, o_hi=0xFFFFFFFE, o_result=0x00000001.
  - Operands changed during BUSY have no effect.
- DIVU 100/7 -> o_result=14, o_hi=2, o_dz=0. DIVU 9/0 -> o_result=0xFFFFFFFF, o_hi=9, o_dz=1, same 32-cycle latency.
- Back-to-back: AND, OR, ADD on consecutive cycles -> three consecutive o_valid pulses. New DIVU accepted in a MULTU's o_valid cycle -> its result arrives 32 edges later.
- Assert i_rst_n=0 at cycle 10 of a MULTU -> outputs zero immediately, o_ready=1. No o_valid for the aborted op; the next op completes normally.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: registered single-cycle logic/arith/compare ops plus
// iterative unsigned shift-add multiply and restoring divide with HI/LO outputs.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [3:0]       i_control,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_zf,
  output logic             o_dz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zf_q, zf_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    alu_res = '0;
    case (i_control)
      OP_AND:  alu_res = i_op1 & i_op2;
      OP_OR:   alu_res = i_op1 | i_op2;
      OP_ADD:  alu_res = i_op1 + i_op2;
      OP_SUB:  alu_res = i_op1 - i_op2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_op1 < i_op2)};
      OP_NOR:  alu_res = ~(i_op1 | i_op2);
      default: alu_res = '0;
    endcase
  end

  // Multiply: acc_hi holds the running partial product, acc_lo the multiplier
  // being shifted out LSB-first while product bits shift in from the top.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out
  // MSB-first and quotient bits in at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    valid_d  = 1'b0;
    result_d = result_q;
    hi_d     = hi_q;
    zf_d     = zf_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (i_control == OP_MULTU || i_control == OP_DIVU) begin
            is_div_d = (i_control == OP_DIVU);
            acc_hi_d = '0;
            acc_lo_d = (i_control == OP_DIVU) ? i_op1 : i_op2;
            opb_d    = (i_control == OP_DIVU) ? i_op2 : i_op1;
            cnt_d    = CW'(WIDTH);
            state_d  = S_BUSY;
          end else begin
            result_d = alu_res;
            hi_d     = '0;
            zf_d     = (alu_res == '0);
            dz_d     = 1'b0;
            valid_d  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // A zero divisor naturally yields all-ones quotient and remainder = dividend.
          result_d = step_lo;
          hi_d     = step_hi;
          zf_d     = (step_lo == '0);
          dz_d     = is_div_q && (opb_q == '0);
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zf_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zf_q     <= zf_d;
      dz_q     <= dz_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_hi     = hi_q;
  assign o_zf     = zf_q;
  assign o_dz     = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: arithmetic reference model with a per-cycle
// compare of every output, plus literal pins and directed reset checks.
module tb_alu_mc;
  localparam int W = 32;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_SUB = 4'b0110, C_SLT = 4'b0111, C_SLTU = 4'b1000,
                         C_MULTU = 4'b1010, C_DIVU = 4'b1011, C_NOR = 4'b1100;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic [3:0]   i_control = 4'b0;
  logic [W-1:0] i_op1 = '0;
  logic [W-1:0] i_op2 = '0;
  logic         o_ready, o_valid, o_zf, o_dz;
  logic [W-1:0] o_result, o_hi;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mc #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_control(i_control),
    .i_op1(i_op1), .i_op2(i_op2), .o_ready(o_ready), .o_valid(o_valid),
    .o_result(o_result), .o_hi(o_hi), .o_zf(o_zf), .o_dz(o_dz)
  );

  always #5 i_clk = ~i_clk;

  // Reference result packed as {dz, hi, lo}.
  function automatic logic [2*W:0] model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [2*W:0]   r;
    r = '0;
    case (c)
      C_AND:   r[W-1:0] = a & b;
      C_OR:    r[W-1:0] = a | b;
      C_ADD:   r[W-1:0] = a + b;
      C_SUB:   r[W-1:0] = a - b;
      C_SLT:   r[W-1:0] = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SLTU:  r[W-1:0] = {{(W-1){1'b0}}, (a < b)};
      C_NOR:   r[W-1:0] = ~(a | b);
      C_MULTU: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r[2*W-1:0] = p;
      end
      C_DIVU:  begin
        if (b == '0) r = {1'b1, a, {W{1'b1}}};
        else         r = {1'b0, a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic zf_of(input logic [2*W:0] r);
    return (r[W-1:0] == '0);
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // Model state: m_left counts edges remaining for an in-flight multi-cycle op.
  int           m_left = 0;
  logic [2*W:0] m_pend = '0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_res = '0, m_hi = '0;
  logic         m_zf = 1'b0, m_dz = 1'b0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_left <= 0; m_valid <= 1'b0; m_res <= '0; m_hi <= '0; m_zf <= 1'b0; m_dz <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_dz, m_hi, m_res} <= m_pend;
          m_zf    <= zf_of(m_pend);
          m_valid <= 1'b1;
        end
      end else if (i_valid) begin
        if (i_control == C_MULTU || i_control == C_DIVU) begin
          m_pend <= model(i_control, i_op1, i_op2);
          m_left <= W;
        end else begin
          {m_dz, m_hi, m_res} <= model(i_control, i_op1, i_op2);
          m_zf    <= zf_of(model(i_control, i_op1, i_op2));
          m_valid <= 1'b1;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      chk("valid",  80'(o_valid),  80'(m_valid));
      chk("ready",  80'(o_ready),  80'(m_left == 0));
      chk("result", 80'(o_result), 80'(m_res));
      chk("hi",     80'(o_hi),     80'(m_hi));
      chk("zf",     80'(o_zf),     80'(m_zf));
      chk("dz",     80'(o_dz),     80'(m_dz));
      if (o_valid)
        $display("txn t=%0t result=%08h hi=%08h zf=%0b dz=%0b", $time, o_result, o_hi, o_zf, o_dz);
    end
  end

  task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    while (m_left != 0 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (m_left != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout at %0t: got busy, required idle", $time);
    end
    i_valid = 1'b1; i_control = c; i_op1 = a; i_op2 = b;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"},  80'(o_ready),  80'(1));
    chk({tag, "_valid"},  80'(o_valid),  80'(0));
    chk({tag, "_result"}, 80'(o_result), 80'(0));
    chk({tag, "_hi"},     80'(o_hi),     80'(0));
    chk({tag, "_zf"},     80'(o_zf),     80'(0));
    chk({tag, "_dz"},     80'(o_dz),     80'(0));
  endtask

  initial begin
    logic [2*W:0] got;
    // Pin the model against hand-computed values.
    got = model(C_ADD, 32'h7FFFFFFF, 32'h1);        chk("pin_add",   80'(got), 80'({1'b0, 32'h0, 32'h80000000}));
    got = model(C_SLT, 32'hFFFFFFFF, 32'h1);        chk("pin_slt",   80'(got), 80'({1'b0, 32'h0, 32'h1}));
    got = model(C_SLTU, 32'hFFFFFFFF, 32'h1);       chk("pin_sltu",  80'(got), 80'({1'b0, 32'h0, 32'h0}));
    got = model(C_NOR, 32'h0, 32'h0);               chk("pin_nor",   80'(got), 80'({1'b0, 32'h0, 32'hFFFFFFFF}));
    got = model(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF); chk("pin_mul", 80'(got), 80'({1'b0, 32'hFFFFFFFE, 32'h1}));
    got = model(C_DIVU, 32'd100, 32'd7);            chk("pin_div",   80'(got), 80'({1'b0, 32'd2, 32'd14}));
    got = model(C_DIVU, 32'd9, 32'd0);              chk("pin_div0",  80'(got), 80'({1'b1, 32'd9, 32'hFFFFFFFF}));

    @(negedge i_clk);
    #1 reset_checks("rst");
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    @(negedge i_clk);

    send(C_ADD, 32'h7FFFFFFF, 32'h1);
    send(C_SUB, 32'd5, 32'd5);
    send(C_SLT, 32'hFFFFFFFF, 32'h1);
    send(C_SLTU, 32'hFFFFFFFF, 32'h1);
    send(C_NOR, 32'h0, 32'h0);
    send(4'b1111, 32'h3, 32'h4);
    send(C_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    send(C_OR, 32'hF0F0F0F0, 32'h0000FF00);
    send(C_ADD, 32'hFFFFFFFF, 32'h2);

    send(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_control = C_ADD; i_op1 = $urandom; i_op2 = $urandom;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    send(C_DIVU, 32'd100, 32'd7);
    send(C_DIVU, 32'd9, 32'd0);

    send(C_MULTU, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 reset_checks("abort");
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    @(negedge i_clk);

    send(C_ADD, 32'd1, 32'd2);
    send(C_DIVU, 32'hDEADBEEF, 32'h1234);
    send(C_MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (W + 4) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
